// File: rtl/ibus_responder_pkg.sv
// Shared fetch-bus types and constants for the instruction-bus responder.
// The ibus_req_t/ibus_resp_t structs are shared with the fetch unit.
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] IMEM_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } ibus_state_e;

endpackage

// File: rtl/ibus_responder_if.sv
// Fetch-side handshake bundle: request from the fetch unit, response and error back.
interface ibus_responder_if;
  import common::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       fetch_err;

  modport master (output ireq, input iresp, input fetch_err);
  modport slave  (input ireq, output iresp, output fetch_err);

endinterface

// File: rtl/ibus_responder_imem_array.sv
// Word-addressed instruction store: combinational read port, synchronous backdoor write port.
module imem_array #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [31:0]      load_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [MEM_WORDS];

  // Contents are deliberately left unreset; the load port initialises them.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/ibus_responder.sv
// Memory-side end of the instruction fetch handshake: one request at a time,
// fixed LATENCY to a single-cycle data_ok, illegal fetches answered with a NOP.
module ibus_responder
  import common::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = IMEM_BASE,
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  ibus_responder_if.slave  ibus,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [31:0]      load_data,
  output logic [31:0]      fetch_cnt
);

  localparam logic [63:0] WORDS_64 = 64'(MEM_WORDS);

  ibus_state_e state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [63:0]      rd_addr;
  logic [63:0]      rd_off;
  logic             rd_legal;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic             capture;

  // With LATENCY=1 the capture happens in the accept cycle, before req_addr_q is loaded.
  assign rd_addr  = (state_q == ST_IDLE) ? ibus.ireq.addr : req_addr_q;
  assign rd_off   = rd_addr - BASE_ADDR;
  assign rd_legal = (rd_addr[1:0] == 2'b00) && (rd_addr >= BASE_ADDR)
                    && ((rd_off >> 2) < WORDS_64);
  assign rd_idx   = rd_off[2 +: IDX_W];

  imem_array #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_imem (
    .clk       (clk),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data (load_data),
    .rd_idx    (rd_idx),
    .rd_data   (rd_word)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    req_addr_d  = req_addr_q;
    data_d      = data_q;
    err_d       = err_q;
    fetch_cnt_d = fetch_cnt_q;
    capture     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ibus.ireq.valid) begin
          req_addr_d = ibus.ireq.addr;
          wait_cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            capture = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      data_d = rd_legal ? rd_word : NOP_INSTR;
      err_d  = ~rd_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      req_addr_q  <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      req_addr_q  <= req_addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign ibus.iresp = '{
    addr_ok: (state_q == ST_IDLE) && ibus.ireq.valid,
    data_ok: (state_q == ST_RESP),
    data:    data_q
  };
  assign ibus.fetch_err = (state_q == ST_RESP) && err_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_ibus_responder.sv
// Bench for ibus_responder: three instances (LATENCY 1, 2, 3) sharing one backdoor
// load port, checked against an address-rule reference model of the memory.
module tb_ibus_responder;
  import common::*;

  localparam int unsigned WORDS = 64;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [5:0]  load_idx;
  logic [31:0] load_data;

  logic        valid   [3];
  logic [63:0] addr    [3];
  logic        addr_ok [3];
  logic        data_ok [3];
  logic        ferr    [3];
  logic [31:0] data    [3];
  logic [31:0] cnt     [3];

  logic [31:0] model_mem [WORDS];
  int          exp_cnt   [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ibus_responder_if bus ();

    assign bus.ireq    = {valid[g], addr[g]};
    assign addr_ok[g]  = bus.iresp.addr_ok;
    assign data_ok[g]  = bus.iresp.data_ok;
    assign data[g]     = bus.iresp.data;
    assign ferr[g]     = bus.fetch_err;

    ibus_responder #(
      .MEM_WORDS (WORDS),
      .LATENCY   (g + 1),
      .BASE_ADDR (BASE)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .ibus      (bus),
      .load_en   (load_en),
      .load_idx  (load_idx),
      .load_data (load_data),
      .fetch_cnt (cnt[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference answer from the address rules: {fetch_err, data}.
  function automatic logic [32:0] refFetch(input logic [63:0] a);
    if ((a % 4) != 0 || a < BASE || a >= BASE + 64'(4 * WORDS))
      return {1'b1, NOP_INSTR};
    return {1'b0, model_mem[int'((a - BASE) / 4)]};
  endfunction

  task automatic loadWord(input int idx, input logic [31:0] val);
    load_en   = 1'b1;
    load_idx  = 6'(idx);
    load_data = val;
    step();
    load_en   = 1'b0;
    model_mem[idx] = val;
  endtask

  // One complete fetch on instance d, starting in an IDLE cycle and ending in the
  // cycle after data_ok. perturb scrambles addr/valid during WAIT; inject writes
  // 32'hDEADBEEF to the fetched word in the capture cycle.
  task automatic applyStimulus(input int d, input logic [63:0] a, input bit hold,
                               input bit perturb, input bit inject);
    int          lat = d + 1;
    int          widx = int'((a - BASE) >> 2);
    logic [32:0] expv;
    valid[d] = 1'b1;
    addr[d]  = a;
    #1;
    checkOutput($sformatf("addr_ok_L%0d", lat), 64'(addr_ok[d]), 64'd1);
    expv = refFetch(a);
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k < lat) begin
        checkOutput($sformatf("early_data_ok_L%0d", lat), 64'(data_ok[d]), 64'd0);
        checkOutput($sformatf("wait_addr_ok_L%0d", lat), 64'(addr_ok[d]), 64'd0);
        checkOutput($sformatf("wait_err_L%0d", lat), 64'(ferr[d]), 64'd0);
        if (perturb) begin
          addr[d] = {$urandom, $urandom};
          if ($urandom_range(1) == 1) valid[d] = 1'b0;
        end
        if (inject && k == lat - 1) begin
          load_en   = 1'b1;
          load_idx  = 6'(widx);
          load_data = 32'hDEAD_BEEF;
        end
      end else begin
        checkOutput($sformatf("data_ok_L%0d", lat), 64'(data_ok[d]), 64'd1);
        checkOutput($sformatf("data_L%0d", lat), 64'(data[d]), 64'(expv[31:0]));
        checkOutput($sformatf("fetch_err_L%0d", lat), 64'(ferr[d]), 64'(expv[32]));
      end
    end
    if (inject) begin
      load_en = 1'b0;
      model_mem[widx] = 32'hDEAD_BEEF;
    end
    valid[d] = hold;
    exp_cnt[d]++;
    step();
    checkOutput($sformatf("post_data_ok_L%0d", lat), 64'(data_ok[d]), 64'd0);
    checkOutput($sformatf("post_err_L%0d", lat), 64'(ferr[d]), 64'd0);
    checkOutput($sformatf("data_hold_L%0d", lat), 64'(data[d]), 64'(expv[31:0]));
    checkOutput($sformatf("fetch_cnt_L%0d", lat), 64'(cnt[d]), 64'(exp_cnt[d]));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [63:0] a;
    int          d;
    rst       = 1'b1;
    load_en   = 1'b0;
    load_idx  = '0;
    load_data = '0;
    for (int i = 0; i < 3; i++) begin
      valid[i]   = 1'b0;
      addr[i]    = '0;
      exp_cnt[i] = 0;
    end
    repeat (3) step();

    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_addr_ok", 64'(addr_ok[i]), 64'd0);
      checkOutput("rst_data_ok", 64'(data_ok[i]), 64'd0);
      checkOutput("rst_data", 64'(data[i]), 64'd0);
      checkOutput("rst_fetch_err", 64'(ferr[i]), 64'd0);
      checkOutput("rst_fetch_cnt", 64'(cnt[i]), 64'd0);
    end
    valid[0] = 1'b1;
    #1;
    checkOutput("rst_addr_ok_valid", 64'(addr_ok[0]), 64'd1);
    valid[0] = 1'b0;
    step();
    rst = 1'b0;

    for (int i = 0; i < WORDS; i++) loadWord(i, $urandom);
    loadWord(0, 32'h0010_0093);

    $display("[TB] basic fetch, LATENCY=2");
    applyStimulus(1, BASE, 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back fetches, LATENCY=3");
    for (int i = 0; i < 8; i++) applyStimulus(2, BASE + 64'(4 * i), (i < 7), 1'b0, 1'b0);
    checkOutput("b2b_fetch_cnt", 64'(cnt[2]), 64'd8);

    $display("[TB] illegal addresses");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i, 64'h8000_0002, 1'b0, 1'b0, 1'b0);
      applyStimulus(i, 64'h7FFF_FFFC, 1'b0, 1'b0, 1'b0);
      applyStimulus(i, BASE + 64'(4 * WORDS), 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] load in capture cycle");
    loadWord(1, 32'h1234_5678);
    applyStimulus(1, BASE + 64'd4, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, BASE + 64'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("reload_word1", 64'(refFetch(BASE + 64'd4)), {31'd0, 1'b0, 32'hDEAD_BEEF});

    $display("[TB] address changes during WAIT, LATENCY=1 timing");
    applyStimulus(2, BASE + 64'd12, 1'b0, 1'b1, 1'b0);
    applyStimulus(1, BASE + 64'd20, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, BASE + 64'd16, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during WAIT");
    valid[2] = 1'b1;
    addr[2]  = BASE + 64'd8;
    step();
    valid[2] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    checkOutput("midrst_fetch_cnt", 64'(cnt[2]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("midrst_no_data_ok", 64'(data_ok[2]), 64'd0);
      step();
    end
    applyStimulus(2, BASE + 64'd8, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized fetches");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) loadWord(int'($urandom_range(WORDS - 1)), $urandom);
      d = int'($urandom_range(2));
      case ($urandom_range(3))
        0: a = BASE + 64'(4 * $urandom_range(WORDS - 1)) + 64'($urandom_range(3, 1));
        1: a = 64'($urandom_range(32'h7FFF_FFFF)) & ~64'h3;
        2: a = BASE + 64'(4 * WORDS) + 64'(4 * $urandom_range(1000));
        default: a = BASE + 64'(4 * $urandom_range(WORDS - 1));
      endcase
      applyStimulus(d, a, 1'b0, 1'($urandom_range(1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Instruction-bus responder: the memory-side end of the `ibus_req_t`/`ibus_resp_t` handshake driven by the fetch unit. It accepts one fetch request at a time, waits a configurable number of cycles, and returns one 32-bit instruction word with a single-cycle `data_ok`. The word comes from an internal word-addressed instruction memory, which a backdoor load port fills. The block sits between the fetch unit and simulation/test memory. It also serves as the latency model the fetch unit's stall logic is verified against.

## Interface
- `MEM_WORDS`, default 4096: instruction memory depth in 32-bit words; must be a power of two.
- `LATENCY`, default 2: cycles from request acceptance to `data_ok`; legal range 1..15.
- `BASE_ADDR`, default 64'h8000_0000: byte address of memory word 0.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ireq` in `ibus_req_t`: `valid`, `addr[63:0]`; the initiator holds both stable until it sees `data_ok`.
- `iresp` out `ibus_resp_t`: `addr_ok`, `data_ok`, `data[31:0]`.
- `fetch_err` out 1: high only together with `data_ok` when the fetch was illegal.
- `load_en` in 1: backdoor write strobe.
- `load_idx` in $clog2(MEM_WORDS): word index to write.
- `load_data` in 32: word to write.
- `fetch_cnt` out 32: count of completed fetches (`data_ok` pulses); wraps at 2^32.

## Operation
- FSM with three states: IDLE, WAIT, RESP.
- IDLE:
  - `addr_ok` = `ireq.valid`, combinational.
  - If `valid` is high, latch `addr` into `req_addr`, load `wait_cnt` = LATENCY-1, and go to WAIT. If LATENCY=1, go straight to RESP.
- WAIT:
  - `addr_ok` = 0.
  - `ireq` is ignored; any change to `ireq.addr` is not observed.
  - `wait_cnt` decrements each cycle.
  - When `wait_cnt` = 1, capture the read result into `data_q` and `err_q`, then go to RESP.
  - With LATENCY=1 this capture happens in the IDLE accept cycle, using `ireq.addr` directly.
- RESP:
  - `data_ok` = 1, `data` = `data_q`, `fetch_err` = `err_q`.
  - `fetch_cnt` increments.
  - Always go to IDLE next. No new request is accepted in the RESP cycle.
- Address check:
  - The fetch is illegal if any of these holds: `addr[1:0]` ≠ 0; `addr` < BASE_ADDR; `(addr - BASE_ADDR) >> 2` ≥ MEM_WORDS.
  - Illegal fetch returns `data` = NOP_INSTR (32'h0000_0013) and `fetch_err` = 1.
  - Legal fetch returns `mem[(addr - BASE_ADDR) >> 2]` and `fetch_err` = 0.
  - The subtraction is 64-bit unsigned; the index is its bits [2 +: $clog2(MEM_WORDS)], used only after the range check passes.
- Load port:
  - Writes `mem[load_idx]` on any cycle `load_en` is high, in any state.
  - Read-before-write: a load in the same cycle as the capture is not visible in that fetch. A load in any earlier cycle is visible.
- `data` holds its last value outside RESP. `fetch_err` is 0 outside RESP.

## Timing
- Reset values:
  - state = IDLE.
  - `addr_ok` is gated by `ireq.valid` only.
  - `data_ok` = 0, `data` = 0, `fetch_err` = 0, `fetch_cnt` = 0, `wait_cnt` = 0.
  - Memory contents are not reset.
- Acceptance cycle T (`valid` & `addr_ok`): `data_ok` is high in cycle T+LATENCY for exactly one cycle.
- Next acceptance is at T+LATENCY+1 at the earliest. Sustained throughput is 1 fetch per LATENCY+1 cycles.
- `rst` mid-operation: the in-flight fetch is discarded, no `data_ok` is issued for it, and `fetch_cnt` = 0 on the next cycle.
- `valid` dropping during WAIT does not cancel the fetch; `data_ok` is still issued.
- `fetch_cnt` wraps from 32'hFFFF_FFFF to 0 without a flag.

## Structure
- `common` package already holds `ibus_req_t` and `ibus_resp_t`.
- Add to `common`: `NOP_INSTR` (32'h0000_0013) and `IMEM_BASE` (64'h8000_0000, the default for BASE_ADDR).
- One sub-module, `imem_array`:
  - MEM_WORDS × 32 storage.
  - One combinational read port (index in, word out) and one synchronous write port (`load_en`, `load_idx`, `load_data`).
- FSM, counters, address check and response registers live in `ibus_responder`.

## Test plan
- LATENCY=2; preload `mem[0]` = 32'h0010_0093; hold `valid`, `addr` = 64'h8000_0000 → `addr_ok` in cycle T, `data_ok` with `data` = 32'h0010_0093 in T+2 only, `fetch_err` = 0, `fetch_cnt` = 1.
- Back-to-back fetches with `valid` held high, `addr` advancing by 4 after each `data_ok`, LATENCY=3 → accepts every 4 cycles; 8 fetches return `mem[0..7]` in order; `fetch_cnt` = 8.
- `addr` = 64'h8000_0002, then 64'h7FFF_FFFC, then BASE + 4·MEM_WORDS → each returns `data` = 32'h0000_0013 with `fetch_err` = 1.
- `load_en` writing `mem[1]` = 32'hDEAD_BEEF in the capture cycle of a fetch to word 1 → old value returned; a repeat fetch returns 32'hDEAD_BEEF.
- `rst` asserted during WAIT → no `data_ok` for that fetch, state IDLE, `fetch_cnt` = 0; a fresh request afterwards completes normally.
- Change `ireq.addr` during WAIT; LATENCY=1 fetch → data matches the latched address; the LATENCY=1 case shows `data_ok` in T+1.
